dmem_arb: RTL and testbench
===========================

# dmem_arb

Two-requester arbiter for one port of the data memory `mem`. Requester 0 is the pipeline MA/MO path. Requester 1 is a secondary master, such as a DMA or debug engine. The block accepts commands over valid/ready handshakes and registers the winning command onto the memory port. It tracks each outstanding read through a tag pipeline and returns the read data to the requester that issued it.

## Interface
Parameters:
- `LOCK_MAX`, default 8: maximum number of consecutive beats that a locked requester 1 may hold the port while requester 0 is waiting.

Ports:
- `iw_clk`  in  1  clock
- `iw_rst`  in  1  synchronous, active-high reset
- `iw_req0_valid`  in  1  requester 0 command valid
- `ow_req0_ready`  out  1  requester 0 command accepted this cycle
- `iw_req0_we`  in  1  1 = store, 0 = load
- `iw_req0_addr`  in  `HBIT_ADDR`+1  word address
- `iw_req0_wdata`  in  `HBIT_ADDR`+1  store data
- `iw_req0_is48`  in  1  48-bit access
- `or_rsp0_valid`  out  1  load data for requester 0 is valid
- `ow_rsp0_rdata`  out  `HBIT_ADDR`+1  load data, wired from `iw_mem_rdata`
- `iw_req1_*`, `ow_req1_ready`, `or_rsp1_valid`, `ow_rsp1_rdata`: same set as requester 0.
- `iw_req1_lock`  in  1  requester 1 requests back-to-back ownership
- `or_mem_we`, `or_mem_addr`, `or_mem_wdata`, `or_mem_is48`  out  1 / 48 / 48 / 1  registered memory command
- `iw_mem_rdata`  in  `HBIT_ADDR`+1  memory read data; valid one cycle after a read command is presented
- `or_owner`  out  1  id of the last accepted requester

## Operation
Grant is combinational from the current-cycle valids and the registered arbitration state.
- `ow_reqN_ready` = grant to N. Exactly one ready is high when any valid is high; both are low during reset.

Default policy is fixed priority: requester 0 wins when both are valid.

Lock behaviour:
- Lock is active when requester 1 was granted last cycle, `iw_req1_lock`=1 and `iw_req1_valid`=1.
- While lock is active, requester 1 wins over requester 0.
- `r_lock_cnt` counts consecutive locked grants taken while requester 0 is valid.
- When `r_lock_cnt` reaches `LOCK_MAX`, requester 0 gets the next grant, and the counter clears.
- The counter also clears on any requester 0 grant and on any cycle where requester 1 is not granted.

On an accept:
- The command is registered into `or_mem_*`.
- `or_owner` is set to the winner.
- Command-stage tag `{r_c_v = ~we, r_c_id = winner}` is set.

With no accept:
- `or_mem_we`=0 and `r_c_v`=0.
- `or_mem_addr`, `or_mem_wdata` and `or_mem_is48` hold their previous values.

Response stage:
- `r_c_v`/`r_c_id` shift into the response state.
- `or_rspN_valid` = `r_c_v` && (`r_c_id`==N), registered.
- `ow_rspN_rdata` = `iw_mem_rdata`, unconditionally wired.

The block never back-pressures responses; requesters must always sink `rsp_valid`.

Reset:
- All `or_*` outputs clear to 0, as do tags and `r_lock_cnt`.
- Reads in flight when reset asserts are discarded, and no `rsp_valid` is produced for them.

## Timing
Throughput is one command per cycle, with no bubbles between owners.
- Accept at edge k: the command appears on `or_mem_*` in cycle k→k+1 and the memory samples it at edge k+1.
  - A store has committed after edge k+1.
  - A load asserts `or_rspN_valid` together with valid `iw_mem_rdata` in cycle k+1→k+2.
- Load latency is 2 edges from accept to response.
- A store and a load to the same address accepted on consecutive edges return the new data.
- Simultaneous valids without lock: requester 0 takes every cycle; requester 1 waits indefinitely unless the RR option is built.
- `iw_req1_lock` dropping mid-burst takes effect on the same-cycle grant.

## Configuration
- `DMEM_ARB_RR_EN` defined: when both are valid and lock is inactive, the grant alternates, and a 1-bit `r_last` records the most recent winner. After reset, `r_last`=1, so requester 0 wins first. Lock and `LOCK_MAX` still apply.
- Undefined: fixed priority to requester 0; `r_last` is absent.

## Test plan
- Requester 0 store, addr 40, wdata 48'h0000_00A1B2C3, `we`=1. Required: ready in the same cycle; `mem.r_mem[40]`==24'hA1B2C3 after 2 edges; no `rsp_valid`.
- Preload `r_mem[50]`=24'h00C0DE, then requester 1 load of addr 50. Required: `or_rsp1_valid`=1 and `ow_rsp1_rdata`=24'h00C0DE exactly 2 edges after accept; `or_rsp0_valid` stays 0.
- Both valid every cycle with loads to 60 and 61, lock=0. Required: fixed build grants requester 0 on all 6 cycles; RR build alternates 0,1,0,1,0,1 with responses routed to the matching id.
- Requester 1 locked, requester 0 continuously valid, `LOCK_MAX`=8. Required: 8 consecutive requester 1 grants, then 1 requester 0 grant, then requester 1 resumes.
- Back-to-back store 24'h112233 then load at addr 70 from requester 0. Required: the response returns 24'h112233.
- Accept a load, then assert `iw_rst` on the next edge. Required: all outputs 0 and no `rsp_valid` for the dropped read.

Source files
------------

// File: rtl/dmem_arb.sv
// dmem_arb: two-requester arbiter for one data-memory port, with tagged read-response routing.
// Optional build macro DMEM_ARB_RR_EN turns the default fixed priority into round-robin.
`ifndef HBIT_ADDR
`define HBIT_ADDR 47
`endif
module dmem_arb #(
    parameter int LOCK_MAX = 8
) (
    input  logic                 iw_clk,
    input  logic                 iw_rst,
    input  logic                 iw_req0_valid,
    output logic                 ow_req0_ready,
    input  logic                 iw_req0_we,
    input  logic [`HBIT_ADDR:0]  iw_req0_addr,
    input  logic [`HBIT_ADDR:0]  iw_req0_wdata,
    input  logic                 iw_req0_is48,
    output logic                 or_rsp0_valid,
    output logic [`HBIT_ADDR:0]  ow_rsp0_rdata,
    input  logic                 iw_req1_valid,
    output logic                 ow_req1_ready,
    input  logic                 iw_req1_we,
    input  logic [`HBIT_ADDR:0]  iw_req1_addr,
    input  logic [`HBIT_ADDR:0]  iw_req1_wdata,
    input  logic                 iw_req1_is48,
    input  logic                 iw_req1_lock,
    output logic                 or_rsp1_valid,
    output logic [`HBIT_ADDR:0]  ow_rsp1_rdata,
    output logic                 or_mem_we,
    output logic [`HBIT_ADDR:0]  or_mem_addr,
    output logic [`HBIT_ADDR:0]  or_mem_wdata,
    output logic                 or_mem_is48,
    input  logic [`HBIT_ADDR:0]  iw_mem_rdata,
    output logic                 or_owner
);
    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] LMAX = CW'(LOCK_MAX);

    logic          r_g1;
    logic [CW-1:0] r_lock_cnt;
    logic          r_c_v;
    logic          r_c_id;
    logic          w_lock;
    logic          w_rr;
    logic          w_g0;
    logic          w_g1;
    logic          w_acc;
    logic          w_we;

`ifdef DMEM_ARB_RR_EN
    logic r_last;
    assign w_rr = ~r_last;
    always_ff @(posedge iw_clk) begin
        if (iw_rst)
            r_last <= 1'b1;
        else if (w_acc)
            r_last <= w_g1;
    end
`else
    assign w_rr = 1'b0;
`endif

    // w_rr: requester 1 wins a contested, unlocked cycle
    assign w_lock = r_g1 & iw_req1_lock & iw_req1_valid;
    assign w_g1   = ~iw_rst & iw_req1_valid &
                    (~iw_req0_valid | (w_lock ? (r_lock_cnt < LMAX) : w_rr));
    assign w_g0   = ~iw_rst & iw_req0_valid & ~w_g1;
    assign w_acc  = w_g0 | w_g1;
    assign w_we   = w_g1 ? iw_req1_we : iw_req0_we;

    assign ow_req0_ready = w_g0;
    assign ow_req1_ready = w_g1;
    assign ow_rsp0_rdata = iw_mem_rdata;
    assign ow_rsp1_rdata = iw_mem_rdata;

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            r_g1          <= 1'b0;
            r_lock_cnt    <= '0;
            r_c_v         <= 1'b0;
            r_c_id        <= 1'b0;
            or_mem_we     <= 1'b0;
            or_mem_addr   <= '0;
            or_mem_wdata  <= '0;
            or_mem_is48   <= 1'b0;
            or_owner      <= 1'b0;
            or_rsp0_valid <= 1'b0;
            or_rsp1_valid <= 1'b0;
        end else begin
            r_g1          <= w_g1;
            r_lock_cnt    <= !w_g1 ? '0 : (w_lock & iw_req0_valid) ? r_lock_cnt + CW'(1) : r_lock_cnt;
            r_c_v         <= w_acc & ~w_we;
            or_mem_we     <= w_acc & w_we;
            or_rsp0_valid <= r_c_v & ~r_c_id;
            or_rsp1_valid <= r_c_v & r_c_id;
            if (w_acc) begin
                r_c_id       <= w_g1;
                or_owner     <= w_g1;
                or_mem_addr  <= w_g1 ? iw_req1_addr : iw_req0_addr;
                or_mem_wdata <= w_g1 ? iw_req1_wdata : iw_req0_wdata;
                or_mem_is48  <= w_g1 ? iw_req1_is48 : iw_req0_is48;
            end
        end
    end
endmodule

// File: tb/tb_dmem_arb.sv
// tb_dmem_arb: randomized scoreboard bench for dmem_arb with a behavioural memory and arbitration model.
`ifndef HBIT_ADDR
`define HBIT_ADDR 47
`endif
module tb_dmem_arb;
    localparam int W  = `HBIT_ADDR + 1;
    localparam int LM = 8;
`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    typedef logic [W-1:0] word_t;
    typedef struct {
        bit    id;
        word_t data;
        int    due;
    } exp_t;

    logic  iw_clk = 1'b0;
    logic  iw_rst;
    logic  iw_req0_valid, ow_req0_ready, iw_req0_we, iw_req0_is48, or_rsp0_valid;
    word_t iw_req0_addr, iw_req0_wdata, ow_rsp0_rdata;
    logic  iw_req1_valid, ow_req1_ready, iw_req1_we, iw_req1_is48, iw_req1_lock, or_rsp1_valid;
    word_t iw_req1_addr, iw_req1_wdata, ow_rsp1_rdata;
    logic  or_mem_we, or_mem_is48, or_owner;
    word_t or_mem_addr, or_mem_wdata, iw_mem_rdata;

    word_t dev_mem[word_t];
    word_t ref_mem[word_t];
    exp_t  q[$];
    exp_t  m_e;
    int    checks = 0, errors = 0, cyc = 0;
    int    m_prev = -1, m_streak = 0, m_last = 1, m_owner = 0, last_win = -1;
    logic  pre_en = 1'b0;
    word_t pre_a, pre_d;

    dmem_arb #(.LOCK_MAX(LM)) dut (
        .iw_clk(iw_clk), .iw_rst(iw_rst),
        .iw_req0_valid(iw_req0_valid), .ow_req0_ready(ow_req0_ready), .iw_req0_we(iw_req0_we),
        .iw_req0_addr(iw_req0_addr), .iw_req0_wdata(iw_req0_wdata), .iw_req0_is48(iw_req0_is48),
        .or_rsp0_valid(or_rsp0_valid), .ow_rsp0_rdata(ow_rsp0_rdata),
        .iw_req1_valid(iw_req1_valid), .ow_req1_ready(ow_req1_ready), .iw_req1_we(iw_req1_we),
        .iw_req1_addr(iw_req1_addr), .iw_req1_wdata(iw_req1_wdata), .iw_req1_is48(iw_req1_is48),
        .iw_req1_lock(iw_req1_lock), .or_rsp1_valid(or_rsp1_valid), .ow_rsp1_rdata(ow_rsp1_rdata),
        .or_mem_we(or_mem_we), .or_mem_addr(or_mem_addr), .or_mem_wdata(or_mem_wdata),
        .or_mem_is48(or_mem_is48), .iw_mem_rdata(iw_mem_rdata), .or_owner(or_owner)
    );

    always #5 iw_clk = ~iw_clk;

    // Memory device: samples the command at the edge, read data valid for the following cycle.
    always @(posedge iw_clk) begin
        if (pre_en) dev_mem[pre_a] = pre_d;
        if (or_mem_we) dev_mem[or_mem_addr] = or_mem_wdata;
        iw_mem_rdata <= dev_mem.exists(or_mem_addr) ? dev_mem[or_mem_addr] : '0;
    end

    function automatic void chk(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(negedge iw_clk) begin
        chk("rsp_onehot", word_t'(or_rsp0_valid & or_rsp1_valid), '0);
        while (q.size() != 0 && q[0].due < cyc) begin
            m_e = q.pop_front();
            chk("rsp_missing_due", word_t'(cyc), word_t'(m_e.due));
        end
        if (or_rsp0_valid | or_rsp1_valid) begin
            if (q.size() == 0)
                chk("rsp_unexpected", word_t'({or_rsp1_valid, or_rsp0_valid}), '0);
            else begin
                m_e = q.pop_front();
                chk("rsp_due", word_t'(cyc), word_t'(m_e.due));
                chk("rsp_id", word_t'(or_rsp1_valid), word_t'(m_e.id));
                chk("rsp_data", m_e.id ? ow_rsp1_rdata : ow_rsp0_rdata, m_e.data);
            end
        end
    end

    task automatic step(input bit v0, input bit w0, input word_t a0, input word_t d0,
                        input bit v1, input bit w1, input word_t a1, input word_t d1, input bit lk);
        bit locked, ew, es0, es1;
        int win;
        es0 = 1'($urandom_range(0, 1));
        es1 = 1'($urandom_range(0, 1));
        iw_req0_valid = v0; iw_req0_we = w0; iw_req0_addr = a0; iw_req0_wdata = d0; iw_req0_is48 = es0;
        iw_req1_valid = v1; iw_req1_we = w1; iw_req1_addr = a1; iw_req1_wdata = d1; iw_req1_is48 = es1;
        iw_req1_lock = lk;
        #1;
        locked = (m_prev == 1) && lk && v1;
        if (iw_rst || !(v0 || v1)) win = -1;
        else if (!v1) win = 0;
        else if (!v0) win = 1;
        else if (locked) win = (m_streak < LM) ? 1 : 0;
        else win = RR ? 1 - m_last : 0;
        last_win = win;
        chk("ready0", word_t'(ow_req0_ready), word_t'(win == 0));
        chk("ready1", word_t'(ow_req1_ready), word_t'(win == 1));
        @(posedge iw_clk);
        cyc++;
        ew = (win == 1) ? w1 : w0;
        if (iw_rst) begin
            q.delete();
            m_prev = -1; m_streak = 0; m_last = 1; m_owner = 0;
        end else begin
            if (win >= 0) begin
                m_owner = win;
                m_last  = win;
                if (ew)
                    ref_mem[(win == 1) ? a1 : a0] = (win == 1) ? d1 : d0;
                else begin
                    m_e.id   = (win == 1);
                    m_e.data = ref_mem.exists((win == 1) ? a1 : a0) ? ref_mem[(win == 1) ? a1 : a0] : '0;
                    m_e.due  = cyc + 1;
                    q.push_back(m_e);
                end
            end
            m_streak = (win == 1) ? m_streak + int'(locked && v0) : 0;
            m_prev   = win;
        end
        #1;
        chk("mem_we", word_t'(or_mem_we), word_t'(win >= 0 && ew));
        chk("owner", word_t'(or_owner), word_t'(m_owner));
        if (win >= 0) begin
            chk("mem_addr", or_mem_addr, (win == 1) ? a1 : a0);
            chk("mem_wdata", or_mem_wdata, (win == 1) ? d1 : d0);
            chk("mem_is48", word_t'(or_mem_is48), word_t'((win == 1) ? es1 : es0));
        end
        @(negedge iw_clk);
    endtask

    task automatic idle();
        step(0, 0, '0, '0, 0, 0, '0, '0, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mem_we"}, word_t'(or_mem_we), '0);
        chk({tag, "_mem_addr"}, or_mem_addr, '0);
        chk({tag, "_mem_wdata"}, or_mem_wdata, '0);
        chk({tag, "_mem_is48"}, word_t'(or_mem_is48), '0);
        chk({tag, "_owner"}, word_t'(or_owner), '0);
        chk({tag, "_rsp"}, word_t'({or_rsp1_valid, or_rsp0_valid}), '0);
    endtask

    initial begin
        int n1;
        bit seen0;
        iw_rst = 1'b1;
        @(negedge iw_clk);
        step(1, 0, 48'd5, '0, 1, 0, 48'd6, '0, 0);
        step(1, 1, 48'd7, 48'd9, 0, 0, '0, '0, 0);
        chk_zero("reset");
        iw_rst = 1'b0;

        step(1, 1, 48'd40, 48'h0000_00A1B2C3, 0, 0, '0, '0, 0);
        idle();
        chk("store40", dev_mem.exists(48'd40) ? dev_mem[48'd40] : '0, 48'h0000_00A1B2C3);

        pre_a = 48'd50; pre_d = 48'h00C0DE; pre_en = 1'b1;
        ref_mem[48'd50] = 48'h00C0DE;
        idle();
        pre_en = 1'b0;
        step(0, 0, '0, '0, 1, 0, 48'd50, '0, 0);
        repeat (3) idle();

        for (int i = 0; i < 6; i++)
            step(1, 0, 48'd60, '0, 1, 0, 48'd61, '0, 0);
        repeat (2) idle();

        step(0, 0, '0, '0, 1, 0, 48'd3, '0, 1);
        n1 = 0; seen0 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 48'd2, '0, 1, i[0], 48'd3 + word_t'(i), word_t'(i), 1);
            if (last_win == 0) seen0 = 1'b1;
            else if (!seen0) n1++;
        end
        chk("lock_run", word_t'(n1), word_t'(LM));
        repeat (2) idle();

        step(1, 1, 48'd70, 48'h112233, 0, 0, '0, '0, 0);
        step(1, 0, 48'd70, '0, 0, 0, '0, '0, 0);
        repeat (3) idle();

        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), word_t'($urandom_range(0, 15)),
                 word_t'({$urandom(), $urandom()}),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), word_t'($urandom_range(0, 15)),
                 word_t'({$urandom(), $urandom()}), $urandom_range(0, 3) != 0);
        repeat (4) idle();

        step(1, 0, 48'd40, '0, 0, 0, '0, '0, 0);
        iw_rst = 1'b1;
        step(1, 0, 48'd41, '0, 1, 0, 48'd42, '0, 0);
        chk_zero("midrst");
        iw_rst = 1'b0;
        repeat (3) idle();
        chk("q_drained", word_t'(q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
